keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed seven-segment display path: scans a 4x4 hex keypad by driving one row low at a time and sensing the columns.
- Debounces the result, emits one key event per physical press through a valid/ready handshake, and accumulates digits into a 16-bit hex number for the CPU or display path.
- Sits at board level beside the display driver and runs on the fast board clock.

Parameters:
- SCAN_DIV, 50000: clock cycles per row period; must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans needed to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  board clock.
- reset  input  1  synchronous, active-low reset.
- col_sense  input  4  keypad columns, active-low, asynchronous (board pull-ups).
- key_ready  input  1  consumer accepts key_code when high with key_valid.
- clear_number  input  1  synchronous clear of entered_number.
- row_drive  output  4  keypad rows, active-low, exactly one row low.
- key_valid  output  1  a key event is pending.
- key_code  output  4  hex value of the pending key.
- key_pressed  output  1  level: debounced key held (PRESSED or DEBOUNCE_RELEASE).
- entered_number  output  16  last four accepted digits; newest in [3:0].
- overflow  output  1  sticky: an event was dropped while key_valid was high.

Behaviour:
- Reset (reset==0 at a clk edge): row_drive=4'b1110, key_valid=0, key_code=0, key_pressed=0, entered_number=0, overflow=0. The row timer, the row index and the synchronizer flops clear, and the FSM goes to IDLE.
- Reset mid-scan or mid-debounce abandons all state. No event is emitted from a partial scan.
- col_sense passes through a 2-flop synchronizer.
- Row timer counts 0..SCAN_DIV-1 and wraps.
- Columns are sampled in the last cycle of the row period (timer==SCAN_DIV-1). row_drive advances to the next row on the following cycle, wrapping row3 to row0. A row is therefore stable for SCAN_DIV cycles.
- A full scan completes when row3 is sampled. The scan result is the first low column found, searching lowest row first, then lowest column. No low column means result = none.
- Key map, row r / col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- FSM is evaluated once per completed scan. cnt = debounce counter.
  - IDLE: result is a key -> DEBOUNCE_PRESS with candidate=key, cnt=1. If DEBOUNCE_SCANS==1, go straight to PRESSED and emit.
  - DEBOUNCE_PRESS:
    - same key -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> PRESSED and emit.
    - different key -> restart with candidate=new key, cnt=1.
    - none -> IDLE.
  - PRESSED: none -> DEBOUNCE_RELEASE with cnt=1 (if DEBOUNCE_SCANS==1, go to IDLE). Any key -> stay.
  - DEBOUNCE_RELEASE: none -> cnt+1; at DEBOUNCE_SCANS -> IDLE. Any key -> PRESSED with no new event.
- Emit is a single-cycle internal pulse, occurring 1 cycle after the sampling edge of the deciding scan.
  - If key_valid==0: key_valid<=1 and key_code<=candidate.
  - If key_valid==1 and not being accepted that cycle: the event is dropped, overflow<=1, and key_code is unchanged.
  - If key_valid&&key_ready in the same cycle as an emit: the new event is loaded (key_valid stays 1).
- key_valid holds with a stable key_code until key_valid&&key_ready, then drops the next cycle.
- entered_number <= {entered_number[11:0], candidate} on every emit, including dropped events.
- clear_number has priority over a simultaneous emit: the result is 0 and that digit is lost.
- overflow clears only on reset.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3; one scan = 16 cycles):
- Press and release: hold col1 low while row1 is driven (key 5) from reset -> key_valid rises 1 cycle after the 3rd full scan, key_code=5, entered_number=16'h0005, key_pressed=1. After release for 3 scans, key_pressed=0 and no second event.
- Digit sequence: press/release 1, 2, A, F with key_ready=1 -> four single-cycle key_valid pulses, entered_number=16'h12AF, overflow=0.
- Bounce: key 3 present for 2 scans, absent 1 scan, present 3 scans -> exactly one event (code 3), emitted after the last 3 scans.
- Handshake overflow: key_ready=0, press 7 then 9 -> key_code stays 7, overflow=1, entered_number=16'h0079. Raising key_ready drops key_valid the next cycle.
- Priority: two keys on row0 col2 and row2 col0 -> code 3. Assert clear_number in the emit cycle -> entered_number=0 while key_valid=1.
- Reset mid-operation: reset low during DEBOUNCE_PRESS (2nd scan) for 1 cycle -> all outputs at reset values, row_drive=4'b1110. The press needs 3 new full scans before emitting.

Source files
------------

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner_if
// Brief    : Key-event handshake between the keypad scanner and its consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;

    modport master (output key_valid, output key_code, input key_ready);
    modport slave  (input key_valid, input key_code, output key_ready);
endinterface
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 hex keypad row scanner with debounce, key-event handshake
//            and a four-digit hex entry register.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [3:0]  col_sense,
    input  wire logic        clear_number,
    output logic      [3:0]  row_drive,
    output logic             key_pressed,
    output logic      [15:0] entered_number,
    output logic             overflow,
    keypad_scanner_if.master key_if
);

    localparam int TIMER_W = $clog2(SCAN_DIV);
    localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_DONE   = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam bit                 SINGLE     = (DEBOUNCE_SCANS == 1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } state_t;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        k = 4'h0;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  4'hF: k = 4'hD;
        endcase
        return k;
    endfunction

    logic [3:0]         col_meta_q, col_sync_q;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         row_q, row_d;
    logic               found_q, found_d;
    logic [3:0]         found_key_q, found_key_d;
    logic               scan_done_q, scan_done_d;
    logic               res_valid_q, res_valid_d;
    logic [3:0]         res_key_q, res_key_d;
    state_t             state_q, state_d;
    logic [3:0]         cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               key_valid_q, key_valid_d;
    logic [3:0]         key_code_q, key_code_d;
    logic [15:0]        number_q, number_d;
    logic               overflow_q, overflow_d;

    logic               w_sample;
    logic [3:0]         w_row_low;
    logic [1:0]         w_col;
    logic               w_emit;
    logic               w_accept;
    logic [CNT_W-1:0]   w_cnt_inc;

    // Row scan: columns are judged in the last cycle of each row period;
    // the first hit of a scan (lowest row, then lowest column) wins.
    always_comb begin
        w_sample    = (timer_q == TIMER_LAST);
        timer_d     = w_sample ? '0 : timer_q + TIMER_W'(1);
        row_d       = w_sample ? row_q + 2'd1 : row_q;
        w_row_low   = ~col_sync_q;
        w_col       = w_row_low[0] ? 2'd0 :
                      w_row_low[1] ? 2'd1 :
                      w_row_low[2] ? 2'd2 : 2'd3;
        found_d     = found_q;
        found_key_d = found_key_q;
        scan_done_d = 1'b0;
        res_valid_d = res_valid_q;
        res_key_d   = res_key_q;
        if (w_sample) begin
            if ((row_q == 2'd0) || !found_q) begin
                found_d     = |w_row_low;
                found_key_d = key_map(row_q, w_col);
            end
            if (row_q == 2'd3) begin
                scan_done_d = 1'b1;
                res_valid_d = found_d;
                res_key_d   = found_key_d;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        w_emit    = 1'b0;
        w_cnt_inc = cnt_q + CNT_ONE;
        if (scan_done_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (res_valid_q) begin
                        cand_d = res_key_q;
                        cnt_d  = CNT_ONE;
                        if (SINGLE) begin
                            state_d = ST_PRESSED;
                            w_emit  = 1'b1;
                        end else begin
                            state_d = ST_DEB_PRESS;
                        end
                    end
                end
                ST_DEB_PRESS: begin
                    if (!res_valid_q) begin
                        state_d = ST_IDLE;
                    end else if (res_key_q == cand_q) begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == CNT_DONE) begin
                            state_d = ST_PRESSED;
                            w_emit  = 1'b1;
                        end
                    end else begin
                        cand_d = res_key_q;
                        cnt_d  = CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (!res_valid_q) begin
                        cnt_d   = CNT_ONE;
                        state_d = SINGLE ? ST_IDLE : ST_DEB_RELEASE;
                    end
                end
                ST_DEB_RELEASE: begin
                    if (res_valid_q) begin
                        state_d = ST_PRESSED;
                    end else begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == CNT_DONE) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A busy output slot drops the new event, but the digit still enters the number.
    always_comb begin
        w_accept    = key_valid_q && key_if.key_ready;
        key_valid_d = key_valid_q && !w_accept;
        key_code_d  = key_code_q;
        overflow_d  = overflow_q;
        if (w_emit) begin
            if (!key_valid_q || w_accept) begin
                key_valid_d = 1'b1;
                key_code_d  = cand_d;
            end else begin
                overflow_d  = 1'b1;
            end
        end
        number_d = number_q;
        if (clear_number) begin
            number_d = 16'h0000;
        end else if (w_emit) begin
            number_d = {number_q[11:0], cand_d};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            col_meta_q  <= 4'hF;
            col_sync_q  <= 4'hF;
            timer_q     <= '0;
            row_q       <= 2'd0;
            found_q     <= 1'b0;
            found_key_q <= 4'h0;
            scan_done_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_key_q   <= 4'h0;
            state_q     <= ST_IDLE;
            cand_q      <= 4'h0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            number_q    <= 16'h0000;
            overflow_q  <= 1'b0;
        end else begin
            col_meta_q  <= col_sense;
            col_sync_q  <= col_meta_q;
            timer_q     <= timer_d;
            row_q       <= row_d;
            found_q     <= found_d;
            found_key_q <= found_key_d;
            scan_done_q <= scan_done_d;
            res_valid_q <= res_valid_d;
            res_key_q   <= res_key_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            number_q    <= number_d;
            overflow_q  <= overflow_d;
        end
    end

    assign row_drive        = ~(4'b0001 << row_q);
    assign key_pressed      = (state_q == ST_PRESSED) || (state_q == ST_DEB_RELEASE);
    assign entered_number   = number_q;
    assign overflow         = overflow_q;
    assign key_if.key_valid = key_valid_q;
    assign key_if.key_code  = key_code_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Directed bench for keypad_scanner with a behavioural 4x4 keypad.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic [3:0]  col_sense;
    logic        clear_number;
    logic [3:0]  row_drive;
    logic        key_pressed;
    logic [15:0] entered_number;
    logic        overflow;
    logic [15:0] keys;          // bit r*4+c = key at row r, column c held down

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    int first_cyc;
    int valid_cycles;
    logic [3:0] hs_q[$];

    keypad_scanner_if kif ();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .col_sense      (col_sense),
        .clear_number   (clear_number),
        .row_drive      (row_drive),
        .key_pressed    (key_pressed),
        .entered_number (entered_number),
        .overflow       (overflow),
        .key_if         (kif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        col_sense = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_drive[r]) col_sense[c] = 1'b0;
    end

    // cyc counts edges since reset release; first_cyc is the first cycle key_valid is high
    always @(posedge clk) begin
        if (!reset) begin
            cyc          <= 0;
            first_cyc    <= -1;
            valid_cycles <= 0;
            hs_q.delete();
        end else begin
            cyc <= cyc + 1;
            if (kif.key_valid && first_cyc < 0) first_cyc <= cyc;
            if (kif.key_valid) valid_cycles <= valid_cycles + 1;
            if (kif.key_valid && kif.key_ready) hs_q.push_back(kif.key_code);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset(input logic [15:0] init_keys, input logic ready);
        @(negedge clk);
        reset         = 1'b0;
        keys          = init_keys;
        kif.key_ready = ready;
        clear_number  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input logic [15:0] k);
        keys = k;
        cycles(80);
        keys = 16'h0000;
        cycles(80);
    endtask

    initial begin
        reset         = 1'b0;
        keys          = 16'h0000;
        kif.key_ready = 1'b0;
        clear_number  = 1'b0;

        // Reset values
        apply_reset(16'h0000, 1'b0);
        check("rst_row_drive", row_drive, 4'b1110);
        check("rst_key_valid", kif.key_valid, 1'b0);
        check("rst_key_code", kif.key_code, 4'h0);
        check("rst_key_pressed", key_pressed, 1'b0);
        check("rst_number", entered_number, 16'h0000);
        check("rst_overflow", overflow, 1'b0);

        // Press and release key 5 (row1 col1)
        apply_reset(16'h0020, 1'b0);
        cycles(60);
        check("t1_latency", first_cyc, 49);
        check("t1_valid", kif.key_valid, 1'b1);
        check("t1_code", kif.key_code, 4'h5);
        check("t1_number", entered_number, 16'h0005);
        check("t1_pressed", key_pressed, 1'b1);
        kif.key_ready = 1'b1;
        cycles(1);
        check("t1_valid_drop", kif.key_valid, 1'b0);
        keys = 16'h0000;
        cycles(80);
        check("t1_released", key_pressed, 1'b0);
        check("t1_events", hs_q.size(), 1);
        check("t1_no_repeat", kif.key_valid, 1'b0);

        // Digit sequence 1, 2, A, F
        apply_reset(16'h0000, 1'b1);
        tap(16'h0001);
        tap(16'h0002);
        tap(16'h0008);
        tap(16'h4000);
        check("t2_events", hs_q.size(), 4);
        check("t2_code0", hs_q[0], 4'h1);
        check("t2_code1", hs_q[1], 4'h2);
        check("t2_code2", hs_q[2], 4'hA);
        check("t2_code3", hs_q[3], 4'hF);
        check("t2_pulse_cycles", valid_cycles, 4);
        check("t2_number", entered_number, 16'h12AF);
        check("t2_overflow", overflow, 1'b0);

        // Bounce on key 3: 2 scans on, 1 off, 3 on
        apply_reset(16'h0004, 1'b1);
        cycles(32);
        keys = 16'h0000;
        cycles(16);
        keys = 16'h0004;
        cycles(48);
        keys = 16'h0000;
        cycles(80);
        check("t3_latency", first_cyc, 97);
        check("t3_events", hs_q.size(), 1);
        check("t3_code", hs_q[0], 4'h3);

        // Handshake overflow: 7 then 9 with consumer stalled
        apply_reset(16'h0000, 1'b0);
        tap(16'h0100);
        tap(16'h0400);
        check("t4_valid", kif.key_valid, 1'b1);
        check("t4_code", kif.key_code, 4'h7);
        check("t4_overflow", overflow, 1'b1);
        check("t4_number", entered_number, 16'h0079);
        kif.key_ready = 1'b1;
        cycles(1);
        check("t4_valid_drop", kif.key_valid, 1'b0);
        check("t4_events", hs_q.size(), 1);
        check("t4_sticky", overflow, 1'b1);

        // Priority of row0 col2 over row2 col0; clear wins over emit
        apply_reset(16'h0104, 1'b0);
        cycles(48);
        clear_number = 1'b1;
        cycles(1);
        clear_number = 1'b0;
        check("t5_valid", kif.key_valid, 1'b1);
        check("t5_code", kif.key_code, 4'h3);
        check("t5_number_cleared", entered_number, 16'h0000);

        // Reset during debounce of key 5 restarts the whole count
        apply_reset(16'h0020, 1'b0);
        cycles(20);
        reset = 1'b0;
        cycles(1);
        check("t6_row_drive", row_drive, 4'b1110);
        check("t6_valid", kif.key_valid, 1'b0);
        check("t6_pressed", key_pressed, 1'b0);
        check("t6_number", entered_number, 16'h0000);
        reset = 1'b1;
        cycles(60);
        check("t6_latency", first_cyc, 49);
        check("t6_code", kif.key_code, 4'h5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
